instr_fetch_queue: RTL and testbench

- Parametrised successor of the single-slot instruction fetcher.
- Owns the PC, predecodes control flow (RV32I plus optional RVC) to compute next-PC, and enqueues fetched instructions into a DEPTH-entry FIFO.
- The decoder drains the FIFO through a valid/ready handshake, which decouples I-cache hits from decoder stalls.
- Sits between the I-cache/branch predictor/register-file JALR read port and the decoder; the ROB redirects it on flush.

---
 rtl/instr_fetch_queue.sv | 196 +++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the PC, predecodes control flow to pick next-PC,
// and buffers fetched instructions in a DEPTH-entry queue drained by the decoder.
module instr_fetch_queue #(
  parameter int          DEPTH       = 4,
  parameter int          DEPTH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter bit          ENABLE_RVC  = 1'b1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic [31:0]            flush_addr_in,
  output logic                   ic_req_out,
  output logic [31:0]            ic_pc_out,
  input  logic                   ic_valid_in,
  input  logic [31:0]            ic_instr_in,
  input  logic                   pred_taken_in,
  output logic [4:0]             rs_jalr_out,
  input  logic [31:0]            rf_value_jalr_in,
  output logic                   deq_valid_out,
  input  logic                   deq_ready_in,
  output logic [31:0]            deq_instr_out,
  output logic [31:0]            deq_addr_out,
  output logic                   deq_pred_taken_out,
  output logic [31:0]            deq_jump_addr_out,
  output logic                   deq_is_rvc_out,
  output logic [DEPTH_WIDTH:0]   count_out
);

  localparam logic [DEPTH_WIDTH:0] FULL_COUNT = (DEPTH_WIDTH + 1)'(DEPTH);

  logic [31:0]            pc;
  logic [DEPTH_WIDTH-1:0] head;
  logic [DEPTH_WIDTH-1:0] tail;
  logic [DEPTH_WIDTH:0]   count;

  logic [31:0] q_instr  [DEPTH];
  logic [31:0] q_addr   [DEPTH];
  logic [31:0] q_target [DEPTH];
  logic        q_taken  [DEPTH];
  logic        q_rvc    [DEPTH];

  logic enq_fire;
  logic deq_fire;
  logic full;

  // ---------------------------------------------------------------
  // Predecode of the word currently returned by the I-cache
  // ---------------------------------------------------------------
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  c_funct3;
  logic [1:0]  c_quad;
  logic        is_rvc;
  logic        op_jal;
  logic        op_jalr;
  logic        op_branch;
  logic        c_jump;
  logic        c_branch;
  logic        c_jr;

  logic [31:0] imm_j;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_cj;
  logic [31:0] imm_cb;

  logic [31:0] fall_pc;
  logic [31:0] pd_target;
  logic        pd_taken;
  logic [31:0] next_pc;

  assign instr    = ic_instr_in;
  assign opcode   = instr[6:0];
  assign c_funct3 = instr[15:13];
  assign c_quad   = instr[1:0];

  // With RVC disabled every word is treated as a 32-bit encoding.
  assign is_rvc    = ENABLE_RVC && (c_quad != 2'b11);

  assign op_jal    = !is_rvc && (opcode == 7'b1101111);
  assign op_jalr   = !is_rvc && (opcode == 7'b1100111);
  assign op_branch = !is_rvc && (opcode == 7'b1100011);

  assign c_jump    = is_rvc && (c_quad == 2'b01) &&
                     ((c_funct3 == 3'b101) || (c_funct3 == 3'b001));
  assign c_branch  = is_rvc && (c_quad == 2'b01) &&
                     ((c_funct3 == 3'b110) || (c_funct3 == 3'b111));
  assign c_jr      = is_rvc && (c_quad == 2'b10) && (c_funct3 == 3'b100) &&
                     (instr[6:2] == 5'd0) && (instr[11:7] != 5'd0);

  assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_cj = {{21{instr[12]}}, instr[8], instr[10:9], instr[6], instr[7],
                   instr[2], instr[11], instr[5:3], 1'b0};
  assign imm_cb = {{24{instr[12]}}, instr[6:5], instr[2], instr[11:10],
                   instr[4:3], 1'b0};

  // Non-control-flow entries carry the fall-through PC as their target.
  always_comb begin
    fall_pc   = is_rvc ? (pc + 32'd2) : (pc + 32'd4);
    pd_target = fall_pc;
    pd_taken  = 1'b0;
    if (op_jal) begin
      pd_target = pc + imm_j;
      pd_taken  = 1'b1;
    end else if (op_jalr) begin
      pd_target = (rf_value_jalr_in + imm_i) & ~32'd1;
      pd_taken  = 1'b1;
    end else if (op_branch) begin
      pd_target = pc + imm_b;
      pd_taken  = pred_taken_in;
    end else if (c_jump) begin
      pd_target = pc + imm_cj;
      pd_taken  = 1'b1;
    end else if (c_branch) begin
      pd_target = pc + imm_cb;
      pd_taken  = pred_taken_in;
    end else if (c_jr) begin
      pd_target = rf_value_jalr_in & ~32'd1;
      pd_taken  = 1'b1;
    end
    next_pc = pd_taken ? pd_target : fall_pc;
  end

  always_comb begin
    rs_jalr_out = 5'd0;
    if (op_jalr) begin
      rs_jalr_out = instr[19:15];
    end else if (c_jr) begin
      rs_jalr_out = instr[11:7];
    end
  end

  // ---------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------
  assign full          = (count == FULL_COUNT);
  assign deq_valid_out = (count != '0);
  assign count_out     = count;
  assign ic_pc_out     = pc;

  // Request deliberately ignores deq_ready_in: a full queue never enqueues.
  assign ic_req_out = rdy_in && !flush_in && !full;
  assign enq_fire   = ic_req_out && ic_valid_in;
  assign deq_fire   = rdy_in && !flush_in && deq_valid_out && deq_ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        pc    <= flush_addr_in;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq_fire) begin
          tail <= tail + DEPTH_WIDTH'(1);
          pc   <= next_pc;
        end
        if (deq_fire) begin
          head <= head + DEPTH_WIDTH'(1);
        end
        if (enq_fire && !deq_fire) begin
          count <= count + (DEPTH_WIDTH + 1)'(1);
        end else if (!enq_fire && deq_fire) begin
          count <= count - (DEPTH_WIDTH + 1)'(1);
        end
      end
    end
  end

  // Payload storage has no reset; occupancy alone decides validity.
  always_ff @(posedge clk_in) begin
    if (enq_fire && !rst_in) begin
      q_instr[tail]  <= instr;
      q_addr[tail]   <= pc;
      q_target[tail] <= pd_target;
      q_taken[tail]  <= pd_taken;
      q_rvc[tail]    <= is_rvc;
    end
  end

  assign deq_instr_out      = q_instr[head];
  assign deq_addr_out       = q_addr[head];
  assign deq_jump_addr_out  = q_target[head];
  assign deq_pred_taken_out = q_taken[head];
  assign deq_is_rvc_out     = q_rvc[head];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus a randomized run against
// an encoder-driven queue model.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic [31:0] flush_addr_in;
  logic        ic_req_out;
  logic [31:0] ic_pc_out;
  logic        ic_valid_in;
  logic [31:0] ic_instr_in;
  logic        pred_taken_in;
  logic [4:0]  rs_jalr_out;
  logic [31:0] rf_value_jalr_in;
  logic        deq_valid_out;
  logic        deq_ready_in;
  logic [31:0] deq_instr_out;
  logic [31:0] deq_addr_out;
  logic        deq_pred_taken_out;
  logic [31:0] deq_jump_addr_out;
  logic        deq_is_rvc_out;
  logic [DW:0] count_out;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  instr_fetch_queue #(
    .DEPTH(DEPTH), .DEPTH_WIDTH(DW), .RESET_PC(32'h0), .ENABLE_RVC(1'b1)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .flush_addr_in(flush_addr_in), .ic_req_out(ic_req_out), .ic_pc_out(ic_pc_out),
    .ic_valid_in(ic_valid_in), .ic_instr_in(ic_instr_in), .pred_taken_in(pred_taken_in),
    .rs_jalr_out(rs_jalr_out), .rf_value_jalr_in(rf_value_jalr_in),
    .deq_valid_out(deq_valid_out), .deq_ready_in(deq_ready_in),
    .deq_instr_out(deq_instr_out), .deq_addr_out(deq_addr_out),
    .deq_pred_taken_out(deq_pred_taken_out), .deq_jump_addr_out(deq_jump_addr_out),
    .deq_is_rvc_out(deq_is_rvc_out), .count_out(count_out)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] target;
    logic        taken;
    logic        rvc;
  } ent_t;

  // Encoders: build instructions from a known offset so the model never decodes.
  function automatic logic [31:0] enc_addi(int rd, int rs1, int imm);
    logic [4:0] d; logic [4:0] s; logic [11:0] i;
    d = rd[4:0]; s = rs1[4:0]; i = imm[11:0];
    return {i, s, 3'b000, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_jal(int rd, int off);
    logic [4:0] d; logic [20:0] o;
    d = rd[4:0]; o = off[20:0];
    return {o[20], o[10:1], o[11], o[19:12], d, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(int rd, int rs1, int imm);
    logic [4:0] d; logic [4:0] s; logic [11:0] i;
    d = rd[4:0]; s = rs1[4:0]; i = imm[11:0];
    return {i, s, 3'b000, d, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_beq(int rs1, int rs2, int off);
    logic [4:0] a; logic [4:0] b; logic [12:0] o;
    a = rs1[4:0]; b = rs2[4:0]; o = off[12:0];
    return {o[12], o[10:5], b, a, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic logic [15:0] enc_cj(int off, logic link);
    logic [11:0] o;
    o = off[11:0];
    return {(link ? 3'b001 : 3'b101), o[11], o[4], o[9:8], o[10], o[6], o[7], o[3:1], o[5], 2'b01};
  endfunction

  function automatic logic [15:0] enc_cb(int rs1p, int off, logic bnez);
    logic [2:0] r; logic [8:0] o;
    r = rs1p[2:0]; o = off[8:0];
    return {(bnez ? 3'b111 : 3'b110), o[8], o[4:3], r, o[7:6], o[2:1], o[5], 2'b01};
  endfunction

  function automatic logic [15:0] enc_cjr(int rs1, logic link);
    logic [4:0] r;
    r = rs1[4:0];
    return {3'b100, link, r, 5'b00000, 2'b10};
  endfunction

  function automatic logic [15:0] enc_caddi(int rd, int imm);
    logic [4:0] r; logic [5:0] i;
    r = rd[4:0]; i = imm[5:0];
    return {3'b000, i[5], r, i[4:0], 2'b01};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0; flush_addr_in = 32'h0; ic_valid_in = 1'b0;
    ic_instr_in = 32'h0; pred_taken_in = 1'b0; rf_value_jalr_in = 32'h0; deq_ready_in = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] addr);
    idle();
    flush_in = 1'b1; flush_addr_in = addr;
    tick();
    flush_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle();
    tick(); tick();
    #1;
    total++; if (count_out !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_out); end
    total++; if (deq_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", deq_valid_out); end
    total++; if (ic_pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", ic_pc_out); end
    rst_in = 1'b0;
    #1;
    total++; if (ic_req_out !== 1'b1) begin bad++; $display("FAIL reset_req got=%b exp=1", ic_req_out); end
  endtask

  task automatic test_fill();
    logic [31:0] addi;
    addi = enc_addi(1, 0, 1);
    ic_instr_in = addi; ic_valid_in = 1'b1; deq_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ic_pc_out !== 32'(4 * i)) begin bad++; $display("FAIL fill_pc got=%h exp=%h", ic_pc_out, 4 * i); end
      tick();
    end
    #1;
    total++; if (count_out !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count_out); end
    total++; if (ic_req_out !== 1'b0) begin bad++; $display("FAIL fill_req got=%b exp=0", ic_req_out); end
    total++; if (ic_pc_out !== 32'h10) begin bad++; $display("FAIL fill_pc_end got=%h exp=10", ic_pc_out); end
    total++; if ({deq_addr_out, deq_instr_out} !== {32'h0, addi}) begin
      bad++; $display("FAIL fill_head got=%h/%h exp=0/%h", deq_addr_out, deq_instr_out, addi);
    end
  endtask

  task automatic test_full_deq();
    deq_ready_in = 1'b1; ic_valid_in = 1'b1;
    #1;
    total++; if (ic_req_out !== 1'b0) begin bad++; $display("FAIL full_req got=%b exp=0", ic_req_out); end
    tick();
    deq_ready_in = 1'b0;
    #1;
    total++; if ({count_out, deq_addr_out, ic_pc_out} !== {3'd3, 32'h4, 32'h10}) begin
      bad++; $display("FAIL full_deq got=%0d/%h/%h exp=3/4/10", count_out, deq_addr_out, ic_pc_out);
    end
    tick();
    #1;
    total++; if ({count_out, ic_pc_out} !== {3'd4, 32'h14}) begin
      bad++; $display("FAIL full_refill got=%0d/%h exp=4/14", count_out, ic_pc_out);
    end
    ic_valid_in = 1'b0; deq_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (deq_addr_out !== 32'(4 + 4 * i)) begin bad++; $display("FAIL drain_addr got=%h exp=%h", deq_addr_out, 4 + 4 * i); end
      tick();
    end
    #1;
    total++; if ({deq_valid_out, count_out} !== {1'b0, 3'd0}) begin
      bad++; $display("FAIL drain_empty got=%b/%0d exp=0/0", deq_valid_out, count_out);
    end
  endtask

  task automatic test_jal();
    do_flush(32'h100);
    ic_instr_in = enc_jal(1, 32'h20); ic_valid_in = 1'b1;
    #1;
    total++; if (rs_jalr_out !== 5'd0) begin bad++; $display("FAIL jal_rs got=%0d exp=0", rs_jalr_out); end
    tick();
    ic_valid_in = 1'b0;
    #1;
    total++; if ({deq_valid_out, deq_addr_out, deq_jump_addr_out, deq_pred_taken_out, deq_is_rvc_out, ic_pc_out}
                 !== {1'b1, 32'h100, 32'h120, 1'b1, 1'b0, 32'h120}) begin
      bad++; $display("FAIL jal got v=%b a=%h t=%h k=%b c=%b pc=%h exp 1/100/120/1/0/120",
                      deq_valid_out, deq_addr_out, deq_jump_addr_out, deq_pred_taken_out, deq_is_rvc_out, ic_pc_out);
    end
  endtask

  task automatic test_branch();
    for (int p = 1; p >= 0; p--) begin
      do_flush(32'h40);
      ic_instr_in = enc_beq(1, 2, -8); ic_valid_in = 1'b1; pred_taken_in = (p == 1);
      tick();
      ic_valid_in = 1'b0;
      #1;
      total++; if ({ic_pc_out, deq_jump_addr_out, deq_pred_taken_out} !== {(p == 1) ? 32'h38 : 32'h44, 32'h38, (p == 1)}) begin
        bad++; $display("FAIL beq_p%0d got pc=%h t=%h k=%b", p, ic_pc_out, deq_jump_addr_out, deq_pred_taken_out);
      end
    end
  endtask

  task automatic test_rvc();
    do_flush(32'h200);
    ic_instr_in = {16'hABCD, enc_cjr(1, 1'b0)}; rf_value_jalr_in = 32'h203; ic_valid_in = 1'b1;
    #1;
    total++; if (rs_jalr_out !== 5'd1) begin bad++; $display("FAIL cjr_rs got=%0d exp=1", rs_jalr_out); end
    tick();
    ic_valid_in = 1'b0;
    #1;
    total++; if ({ic_pc_out, deq_jump_addr_out, deq_pred_taken_out, deq_is_rvc_out} !== {32'h202, 32'h202, 1'b1, 1'b1}) begin
      bad++; $display("FAIL cjr got pc=%h t=%h k=%b c=%b exp 202/202/1/1", ic_pc_out, deq_jump_addr_out, deq_pred_taken_out, deq_is_rvc_out);
    end
    do_flush(32'h50);
    ic_instr_in = {16'h1234, enc_caddi(5, 3)}; ic_valid_in = 1'b1;
    tick();
    ic_valid_in = 1'b0;
    #1;
    total++; if ({ic_pc_out, deq_addr_out, deq_jump_addr_out, deq_pred_taken_out, deq_is_rvc_out}
                 !== {32'h52, 32'h50, 32'h52, 1'b0, 1'b1}) begin
      bad++; $display("FAIL caddi got pc=%h a=%h t=%h k=%b c=%b exp 52/50/52/0/1",
                      ic_pc_out, deq_addr_out, deq_jump_addr_out, deq_pred_taken_out, deq_is_rvc_out);
    end
  endtask

  task automatic test_flush_stall();
    do_flush(32'h0);
    ic_instr_in = enc_addi(2, 0, 5); ic_valid_in = 1'b1;
    tick(); tick(); tick();
    #1;
    total++; if (count_out !== 3'd3) begin bad++; $display("FAIL pre_flush_count got=%0d exp=3", count_out); end
    flush_in = 1'b1; flush_addr_in = 32'h800; deq_ready_in = 1'b1;
    #1;
    total++; if (ic_req_out !== 1'b0) begin bad++; $display("FAIL flush_req got=%b exp=0", ic_req_out); end
    tick();
    flush_in = 1'b0; deq_ready_in = 1'b0; ic_valid_in = 1'b0;
    #1;
    total++; if ({count_out, deq_valid_out, ic_pc_out} !== {3'd0, 1'b0, 32'h800}) begin
      bad++; $display("FAIL flush got cnt=%0d v=%b pc=%h exp 0/0/800", count_out, deq_valid_out, ic_pc_out);
    end
    ic_valid_in = 1'b1;
    tick(); tick();
    rdy_in = 1'b0; flush_in = 1'b1; flush_addr_in = 32'h1234; deq_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ic_req_out !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", ic_req_out); end
      tick();
      #1;
      total++; if ({count_out, ic_pc_out, deq_addr_out} !== {3'd2, 32'h808, 32'h800}) begin
        bad++; $display("FAIL stall_hold got cnt=%0d pc=%h a=%h exp 2/808/800", count_out, ic_pc_out, deq_addr_out);
      end
    end
    idle();
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    ent_t        h;
    logic [31:0] mpc;
    logic [31:0] rfv;
    logic [31:0] tgt;
    logic [31:0] ins;
    logic [4:0]  rs_e;
    logic        tk;
    logic        rvc;
    logic        pred;
    logic        req_e;
    int          kind;
    int          off;
    int          r;
    do_flush(32'h1000);
    mpc = 32'h1000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy_in        = ($urandom_range(0, 9) != 0);
      flush_in      = ($urandom_range(0, 29) == 0);
      flush_addr_in = $urandom & 32'hFFFF_FFFE;
      ic_valid_in   = ($urandom_range(0, 3) != 0);
      deq_ready_in  = ($urandom_range(0, 1) == 1);
      pred          = ($urandom_range(0, 1) == 1);
      rfv           = $urandom;
      kind          = $urandom_range(0, 9);
      rs_e = 5'd0; tk = 1'b0; rvc = 1'b0; ins = 32'h0; tgt = mpc + 32'd4;
      case (kind)
        0: begin ins = enc_addi($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 4095)); end
        1: begin
          off = $urandom_range(0, 1048575) * 2 - 1048576;
          ins = enc_jal($urandom_range(0, 31), off); tgt = mpc + off; tk = 1'b1;
        end
        2: begin
          off = $urandom_range(0, 4095) - 2048; r = $urandom_range(0, 31);
          ins = enc_jalr($urandom_range(0, 31), r, off); tgt = (rfv + off) & 32'hFFFF_FFFE;
          tk = 1'b1; rs_e = r[4:0];
        end
        3: begin
          off = $urandom_range(0, 4095) * 2 - 4096;
          ins = enc_beq($urandom_range(0, 31), $urandom_range(0, 31), off); tgt = mpc + off; tk = pred;
        end
        4, 5: begin
          off = $urandom_range(0, 2047) * 2 - 2048;
          ins = {16'($urandom), enc_cj(off, kind == 5)}; tgt = mpc + off; tk = 1'b1; rvc = 1'b1;
        end
        6, 7: begin
          off = $urandom_range(0, 255) * 2 - 256;
          ins = {16'($urandom), enc_cb($urandom_range(0, 7), off, kind == 7)}; tgt = mpc + off; tk = pred; rvc = 1'b1;
        end
        8: begin
          r = $urandom_range(1, 31);
          ins = {16'($urandom), enc_cjr(r, ($urandom_range(0, 1) == 1))}; tgt = rfv & 32'hFFFF_FFFE;
          tk = 1'b1; rvc = 1'b1; rs_e = r[4:0];
        end
        default: begin
          ins = {16'($urandom), enc_caddi($urandom_range(0, 31), $urandom_range(0, 63))};
          tgt = mpc + 32'd2; rvc = 1'b1;
        end
      endcase
      ic_instr_in = ins; pred_taken_in = pred; rf_value_jalr_in = rfv;
      req_e = rdy_in && !flush_in && (q.size() < DEPTH);
      #1;
      total++; if ({ic_req_out, ic_pc_out, rs_jalr_out} !== {req_e, mpc, rs_e}) begin
        bad++; $display("FAIL rnd_fetch cyc=%0d got req=%b pc=%h rs=%0d exp req=%b pc=%h rs=%0d",
                        cyc, ic_req_out, ic_pc_out, rs_jalr_out, req_e, mpc, rs_e);
      end
      total++; if ({count_out, deq_valid_out} !== {3'(q.size()), q.size() != 0}) begin
        bad++; $display("FAIL rnd_count cyc=%0d got=%0d/%b exp=%0d", cyc, count_out, deq_valid_out, q.size());
      end
      if (q.size() != 0) begin
        h = q[0];
        total++; if ({deq_instr_out, deq_addr_out, deq_jump_addr_out, deq_pred_taken_out, deq_is_rvc_out}
                     !== {h.instr, h.addr, h.target, h.taken, h.rvc}) begin
          bad++; $display("FAIL rnd_head cyc=%0d got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", cyc,
                          deq_instr_out, deq_addr_out, deq_jump_addr_out, deq_pred_taken_out, deq_is_rvc_out,
                          h.instr, h.addr, h.target, h.taken, h.rvc);
        end
      end
      if (rdy_in) begin
        if (flush_in) begin
          q.delete();
          mpc = flush_addr_in;
        end else begin
          if (q.size() != 0 && deq_ready_in) void'(q.pop_front());
          if (req_e && ic_valid_in) begin
            e.instr = ins; e.addr = mpc; e.target = tgt; e.taken = tk; e.rvc = rvc;
            q.push_back(e);
            mpc = tk ? tgt : (mpc + (rvc ? 32'd2 : 32'd4));
          end
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    @(negedge clk_in);
    test_reset();
    test_fill();
    test_full_deq();
    test_jal();
    test_branch();
    test_rvc();
    test_flush_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
